// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared memory-port types: RAM command encoding, arbiter
//                FSM states and requester grant identifiers.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Command presented to the RAM; also used by the cpu and the RAM model
    typedef enum logic [1:0] {
        MNONE  = 2'b00,
        MREAD  = 2'b01,
        MWRITE = 2'b10
    } mem_cmd_e;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        DONE = 2'b11
    } arb_state_e;

    // Which requester owns the port
    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } grant_e;

endpackage
`default_nettype wire

// File: rtl/arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : arb_rr_pick
//  Description : Combinational 2-way round-robin pick between the fetch and
//                data requesters. On a tie the requester that did not win
//                the previous tie is chosen.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_rr_pick
    import mem_pkg::*;
(
    input  logic   f_req,
    input  logic   d_req,
    input  grant_e last_grant,
    output grant_e grant,
    output logic   valid
);

    // Lone requester wins outright; a tie goes to the opposite of last_grant
    always_comb begin
        valid = f_req | d_req;
        grant = FETCH;
        if (f_req && d_req) begin
            grant = (last_grant == FETCH) ? DATA : FETCH;
        end else if (d_req) begin
            grant = DATA;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one RAM port between instruction fetch and
//                load/store. Each access is sequenced IDLE -> RD/WR -> DONE;
//                the done pulse coincides with the registered read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int AW         = 9,
    parameter int DW         = 16,
    parameter int RD_LATENCY = 1
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_done,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output mem_cmd_e      mem_cmd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] write_data,
    input  logic [DW-1:0] read_data
);

    // Counter only has to hold RD_LATENCY down to 1
    localparam int c_cnt_w = $clog2(RD_LATENCY + 1);

    arb_state_e           r_state,      w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt,        w_cnt_nxt;
    grant_e               r_last_grant, w_last_nxt;
    grant_e               r_cur_grant,  w_cur_nxt;
    mem_cmd_e             r_mem_cmd,    w_cmd_nxt;
    logic [AW-1:0]        r_mem_addr,   w_addr_nxt;
    logic [DW-1:0]        r_write_data, w_wdata_nxt;
    logic                 r_f_done,     w_f_done_nxt;
    logic                 r_d_done,     w_d_done_nxt;
    logic [DW-1:0]        r_f_rdata,    w_f_rdata_nxt;
    logic [DW-1:0]        r_d_rdata,    w_d_rdata_nxt;

    grant_e               w_pick_grant;
    logic                 w_pick_valid;

    arb_rr_pick u_pick (
        .f_req      (f_req),
        .d_req      (d_req),
        .last_grant (r_last_grant),
        .grant      (w_pick_grant),
        .valid      (w_pick_valid)
    );

    // Next-state and next-output logic; done pulses default low every cycle
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_last_nxt    = r_last_grant;
        w_cur_nxt     = r_cur_grant;
        w_cmd_nxt     = r_mem_cmd;
        w_addr_nxt    = r_mem_addr;
        w_wdata_nxt   = r_write_data;
        w_f_done_nxt  = 1'b0;
        w_d_done_nxt  = 1'b0;
        w_f_rdata_nxt = r_f_rdata;
        w_d_rdata_nxt = r_d_rdata;

        case (r_state)
            IDLE: begin
                w_cmd_nxt = MNONE;
                if (w_pick_valid) begin
                    w_cur_nxt = w_pick_grant;
                    // Only a contested grant moves the round-robin pointer
                    if (f_req && d_req) begin
                        w_last_nxt = w_pick_grant;
                    end
                    // Address and data are latched here; later input changes are ignored
                    if ((w_pick_grant == DATA) && d_we) begin
                        w_cmd_nxt   = MWRITE;
                        w_addr_nxt  = d_addr;
                        w_wdata_nxt = d_wdata;
                        w_state_nxt = WR;
                    end else begin
                        w_cmd_nxt   = MREAD;
                        w_addr_nxt  = (w_pick_grant == FETCH) ? f_addr : d_addr;
                        w_cnt_nxt   = c_cnt_w'(RD_LATENCY);
                        w_state_nxt = RD;
                    end
                end
            end

            RD: begin
                if (r_cnt == c_cnt_w'(1)) begin
                    // Last MREAD cycle: read_data is valid now
                    if (r_cur_grant == FETCH) begin
                        w_f_rdata_nxt = read_data;
                        w_f_done_nxt  = 1'b1;
                    end else begin
                        w_d_rdata_nxt = read_data;
                        w_d_done_nxt  = 1'b1;
                    end
                    w_cmd_nxt   = MNONE;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_w'(1);
                end
            end

            WR: begin
                w_d_done_nxt = 1'b1;
                w_cmd_nxt    = MNONE;
                w_state_nxt  = DONE;
            end

            DONE: begin
                // Requests are ignored here so a requester dropping req at this edge is never reissued
                w_cmd_nxt   = MNONE;
                w_state_nxt = IDLE;
            end

            default: begin
                w_cmd_nxt   = MNONE;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_last_grant <= FETCH;
            r_cur_grant  <= FETCH;
            r_mem_cmd    <= MNONE;
            r_mem_addr   <= '0;
            r_write_data <= '0;
            r_f_done     <= 1'b0;
            r_d_done     <= 1'b0;
            r_f_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_last_grant <= w_last_nxt;
            r_cur_grant  <= w_cur_nxt;
            r_mem_cmd    <= w_cmd_nxt;
            r_mem_addr   <= w_addr_nxt;
            r_write_data <= w_wdata_nxt;
            r_f_done     <= w_f_done_nxt;
            r_d_done     <= w_d_done_nxt;
            r_f_rdata    <= w_f_rdata_nxt;
            r_d_rdata    <= w_d_rdata_nxt;
        end
    end

    assign f_done     = r_f_done;
    assign f_rdata    = r_f_rdata;
    assign d_done     = r_d_done;
    assign d_rdata    = r_d_rdata;
    assign mem_cmd    = r_mem_cmd;
    assign mem_addr   = r_mem_addr;
    assign write_data = r_write_data;

endmodule
`default_nettype wire
